// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: command-driven LED pattern controller (off / solid / blink / counted burst).
// Latency: an accepted command shows on led one clk later; phases last exactly on*CLK_DIV / off*CLK_DIV clks.
// Backpressure: cmd_ready drops only while a burst runs; idle, solid and blink are preempted immediately.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake; accepted when both are high
//   cmd_mode                     0=OFF, 1=SOLID, 2=BLINK, 3=BURST
//   cmd_on / cmd_off             ON / OFF phase lengths in base ticks
//   cmd_reps                     number of ON/OFF cycles for BURST
//   led                          registered LED drive
//   busy                         burst in progress (always ~cmd_ready)
//   done                         one-cycle pulse when a burst completes
module led_blink_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_on,
  input  logic [CNT_W-1:0] cmd_off,
  input  logic [7:0]       cmd_reps,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] on_q, off_q;
  logic [7:0]       reps_q;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [7:0]       rep_q, rep_d;
  logic [DIV_W-1:0] pre_cnt;
  logic             led_q;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;
  logic             off_end;

  // Only a running burst blocks new commands; blink shares ON/OFF states
  // but stays preemptible, so the latched mode decides.
  assign busy      = ((state_q == ST_ON) || (state_q == ST_OFF)) && (mode_q == MODE_BURST);
  assign cmd_ready = ~busy;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (pre_cnt == DIV_W'(CLK_DIV - 1));
  assign led       = led_q;
  assign done      = done_q;

  // Prescaler restarts on every accepted command so the first tick lands
  // exactly CLK_DIV cycles after acceptance, keeping phases aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (accept || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    off_end = 1'b0;

    if (accept) begin
      // A new command always wins over a tick or boundary in the same cycle.
      phase_d = '0;
      rep_d   = '0;
      case (cmd_mode)
        MODE_OFF:   state_d = ST_IDLE;
        MODE_SOLID: state_d = ST_SOLID;
        MODE_BLINK: begin
          if (cmd_on == '0) begin
            state_d = ST_IDLE;
          end else if (cmd_off == '0) begin
            state_d = ST_SOLID;
          end else begin
            state_d = ST_ON;
          end
        end
        default: begin
          if (cmd_on == '0) begin
            state_d = ST_IDLE;
          end else if (cmd_reps == 8'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ON;
          end
        end
      endcase
    end else if (tick) begin
      case (state_q)
        ST_ON: begin
          if (phase_q == on_q - CNT_W'(1)) begin
            phase_d = '0;
            // A zero-length OFF phase (burst only) folds straight into the
            // end-of-OFF decision so ON phases run back to back.
            if (off_q == '0) begin
              off_end = 1'b1;
            end else begin
              state_d = ST_OFF;
            end
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (phase_q == off_q - CNT_W'(1)) begin
            phase_d = '0;
            off_end = 1'b1;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (off_end) begin
        if (mode_q == MODE_BURST) begin
          if (rep_q == reps_q - 8'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d   = rep_q + 8'd1;
            state_d = ST_ON;
          end
        end else begin
          state_d = ST_ON;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      rep_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      led_q   <= (state_d == ST_SOLID) || (state_d == ST_ON);
      done_q  <= done_d;
    end
  end

  // Command fields are only consulted after acceptance, so they are
  // captured once and the inputs may change freely afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_OFF;
      on_q   <= '0;
      off_q  <= '0;
      reps_q <= '0;
    end else if (accept) begin
      mode_q <= cmd_mode;
      on_q   <= cmd_on;
      off_q  <= cmd_off;
      reps_q <= cmd_reps;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
module tb_led_blink_ctrl;

  localparam int D = 4;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [9:0] cmd_on;
  logic [9:0] cmd_off;
  logic [7:0] cmd_reps;
  logic       led;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the last accepted command.
  int m_mode = 0;
  int m_on   = 0;
  int m_off  = 0;
  int m_reps = 0;

  led_blink_ctrl #(.CLK_DIV(D), .DIV_W(4), .CNT_W(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_on    (cmd_on),
    .cmd_off   (cmd_off),
    .cmd_reps  (cmd_reps),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected {led, busy, done, cmd_ready} k cycles after the accepting edge
  // (k=0 is the first sample after that edge), from the pattern definitions.
  function automatic logic [3:0] model(input int k);
    logic l, b, d;
    int   per, total;
    l = 1'b0; b = 1'b0; d = 1'b0;
    case (m_mode)
      1: l = 1'b1;
      2: begin
        if (m_on == 0)       l = 1'b0;
        else if (m_off == 0) l = 1'b1;
        else                 l = ((k % ((m_on + m_off) * D)) < m_on * D);
      end
      3: begin
        if (m_on != 0) begin
          if (m_reps == 0) begin
            d = (k == 0);
          end else begin
            per   = (m_on + m_off) * D;
            total = m_reps * per;
            if (k < total) begin
              l = ((k % per) < m_on * D);
              b = 1'b1;
            end else begin
              d = (k == total);
            end
          end
        end
      end
      default: ;
    endcase
    return {l, b, d, ~b};
  endfunction

  task automatic check_outputs(input int k);
    logic [3:0] e;
    e = model(k);
    check("led",       led,       e[3]);
    check("busy",      busy,      e[2]);
    check("done",      done,      e[1]);
    check("cmd_ready", cmd_ready, e[0]);
  endtask

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic issue(input int mode, input int on, input int off, input int reps);
    check("ready_at_issue", cmd_ready, 1'b1);
    cmd_mode  = 2'(mode);
    cmd_on    = 10'(on);
    cmd_off   = 10'(off);
    cmd_reps  = 8'(reps);
    cmd_valid = 1'b1;
    m_mode = mode; m_on = on; m_off = off; m_reps = reps;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run(input int mode, input int on, input int off, input int reps, input int ncyc);
    issue(mode, on, off, reps);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check_outputs(k);
    end
  endtask

  initial begin
    int total, dcount, ncyc, mode, on, off, reps;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_on    = '0;
    cmd_off   = '0;
    cmd_reps  = '0;

    // Reset state, then idle for 100 cycles.
    repeat (3) @(negedge clk);
    check_outputs(0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_led", led, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // SOLID then OFF.
    run(1, 0, 0, 0, 20);
    run(0, 0, 0, 0, 10);

    // BLINK on=2 off=3: three full periods.
    run(2, 2, 3, 0, 60);
    run(0, 0, 0, 0, 4);

    // BURST on=1 off=1 reps=3 with a SOLID command held pending throughout.
    issue(3, 1, 1, 3);
    total = 3 * 2 * D;
    cmd_mode  = 2'd1;
    cmd_valid = 1'b1;
    dcount = 0;
    for (int k = 0; k < total + 6; k++) begin
      @(negedge clk);
      check_outputs(k);
      if (done) dcount++;
      if (k == total - 1) cmd_valid = 1'b0;
    end
    check("burst_done_count", dcount, 1);

    // Preemption: SOLID lands on a tick mid-ON of BLINK 5/5.
    run(2, 5, 5, 0, 12);
    run(1, 0, 0, 0, 30);
    // Preemption exactly on the ON->OFF boundary tick; new blink must start
    // its own phase from a freshly cleared prescaler.
    run(2, 5, 5, 0, 20);
    run(2, 1, 2, 0, 30);

    // Degenerate commands.
    run(3, 2, 2, 0, 10);
    run(2, 0, 3, 0, 10);
    run(2, 3, 0, 0, 20);
    run(3, 1, 0, 3, 3 * D + 4);

    // Asynchronous reset in the middle of a burst.
    run(3, 2, 2, 4, 20);
    @(posedge clk);
    #1 check_outputs(20);
    #2 reset_n = 1'b0;
    #1;
    check("arst_led",   led,       1'b0);
    check("arst_busy",  busy,      1'b0);
    check("arst_done",  done,      1'b0);
    check("arst_ready", cmd_ready, 1'b1);
    m_mode = 0;
    repeat (3) begin
      @(negedge clk);
      check_outputs(0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_outputs(i);
    end

    // Randomized command sequence; blink runs are frequently preempted.
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 3));
      on   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      off  = int'($urandom_range(0, 3));
      reps = int'($urandom_range(0, 4));
      if (mode == 3 && on != 0 && reps != 0)
        ncyc = reps * (on + off) * D + 1 + int'($urandom_range(0, 6));
      else
        ncyc = int'($urandom_range(1, 40));
      run(mode, on, off, reps, ncyc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
